alu_arbiter: RTL and testbench

- Shares one combinational 32-bit ALU (operands A, B, opcode ALUOp, result C) between two requesters.
- Arbitration is round-robin.
- Operands and opcode are latched and presented to the ALU for one cycle. The result is registered and returned on a single response channel tagged with the requester ID.
- Sits between the multi-unit datapath and the shared ALU instance.

---
 rtl/alu_arbiter.sv | 108 ++++++++++
 tb/tb_alu_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional ALU_ARB_BUSY_CNT_EN adds a busy_cnt output counting non-IDLE cycles.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data
`ifdef ALU_ARB_BUSY_CNT_EN
  ,
  output logic [31:0]      busy_cnt
`endif
);

  // Handshake: a transfer happens on any edge where valid && ready are both high;
  // ready is only offered in IDLE, to the granted requester, and never during reset.
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             rr_ptr;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] a_q, b_q;
  logic [OPW-1:0]   op_q;
  logic             id_q;

  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) grant_id = rr_ptr;
    else                          grant_id = req1_valid;
    accept     = (state == IDLE) && (req0_valid || req1_valid) && !reset;
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand latch; the ALU only ever sees these registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      id_q   <= 1'b0;
    end else if (accept) begin
      rr_ptr <= !grant_id;
      id_q   <= grant_id;
      a_q    <= grant_id ? req1_a  : req0_a;
      b_q    <= grant_id ? req1_b  : req0_b;
      op_q   <= grant_id ? req1_op : req0_op;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data <= '0;
      rsp_id   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_data <= alu_c;
      rsp_id   <= id_q;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign rsp_valid = (state == RESP);

`ifdef ALU_ARB_BUSY_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              busy_cnt <= '0;
    else if (state != IDLE) busy_cnt <= busy_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with an adder ALU stub
// (alu_c = alu_a + alu_b + alu_op).
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int OPW   = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [OPW-1:0]   req0_op;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_c;
  logic [OPW-1:0]   alu_op;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0] rsp_data;
`ifdef ALU_ARB_BUSY_CNT_EN
  logic [31:0]      busy_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] exp_q[$];
  logic           ord_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign alu_c = alu_a + alu_b + 32'(alu_op);

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef ALU_ARB_BUSY_CNT_EN
    , .busy_cnt(busy_cnt)
`endif
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) cycle();
    @(negedge clk);
    reset = 1'b0;
    cycle();
  endtask

  task automatic drive0(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [OPW-1:0] op);
    req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic drive1(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [OPW-1:0] op);
    req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
  endtask

  // Waits (bounded) for rsp_valid and compares the response.
  task automatic expect_rsp(input string tag, input logic exp_id, input logic [WIDTH-1:0] exp_data);
    int n = 0;
    while (!rsp_valid && n < 8) begin
      cycle();
      n++;
    end
    check({tag, "_valid"}, rsp_valid, 1'b1);
    check({tag, "_id"}, rsp_id, exp_id);
    check({tag, "_data"}, rsp_data, exp_data);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int last_acc;
    int n_acc;
    logic [WIDTH:0] exp_rsp;

    reset = 1'b1;
    rsp_ready = 1'b1;
    clear_inputs();
    req0_valid = 1'b1;
    #1;
    check("rst_req0_ready", req0_ready, 1'b0);
    check("rst_req1_ready", req1_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_alu", {alu_a, alu_b, 29'd0, alu_op}, 0);
    do_reset();

    // single op: ready now, response two edges later
    drive0(32'hF0F0_F0F0, 32'd8, 3'b101);
    #1;
    check("single_ready0", req0_ready, 1'b1);
    check("single_ready1", req1_ready, 1'b0);
    cycle();
    req0_valid = 1'b0;
    req0_a = 32'hDEAD_BEEF;
    #1;
    check("single_exec_ready", req0_ready, 1'b0);
    check("single_alu_a", alu_a, 32'hF0F0_F0F0);
    check("single_alu_op", alu_op, 3'b101);
    cycle();
    check("single_lat_valid", rsp_valid, 1'b1);
    expect_rsp("single", 1'b0, 32'hF0F0_F0FD);
    cycle();
    check("single_done", rsp_valid, 1'b0);

    // contention from reset: req0 first, then req1
    do_reset();
    drive0(32'd1, 32'd2, 3'd0);
    drive1(32'd10, 32'd20, 3'd1);
    #1;
    check("cont_ready0", req0_ready, 1'b1);
    check("cont_ready1", req1_ready, 1'b0);
    cycle();
    req0_valid = 1'b0;
    expect_rsp("cont_r0", 1'b0, 32'd3);
    cycle();
    check("cont_ready1_2", req1_ready, 1'b1);
    check("cont_ready0_2", req0_ready, 1'b0);
    cycle();
    req1_valid = 1'b0;
    expect_rsp("cont_r1", 1'b1, 32'd31);
    cycle();

    // fairness: both held valid, rsp_ready high
    do_reset();
    drive0(32'd100, 32'd1, 3'd2);
    drive1(32'd200, 32'd3, 3'd4);
    ord_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_q.delete();
    last_acc = -1;
    n_acc = 0;
    #1;
    for (int cyc = 0; cyc < 18; cyc++) begin
      check("fair_onehot", req0_ready & req1_ready, 1'b0);
      if (req0_ready || req1_ready) begin
        if (ord_q.size() == 0) check("fair_extra_accept", 1'b1, 1'b0);
        else check("fair_order", req1_ready, ord_q.pop_front());
        if (last_acc >= 0) check("fair_gap", cyc - last_acc, 3);
        last_acc = cyc;
        n_acc++;
        exp_q.push_back(req1_ready ? {1'b1, 32'd207} : {1'b0, 32'd103});
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("fair_extra_rsp", 1'b1, 1'b0);
        else begin
          exp_rsp = exp_q.pop_front();
          check("fair_rsp", {rsp_id, rsp_data}, exp_rsp);
        end
      end
      cycle();
    end
    check("fair_count", n_acc, 6);
    check("fair_drained", exp_q.size(), 0);

    // backpressure: response held, no readies, resume after handshake
    do_reset();
    rsp_ready = 1'b0;
    drive0(32'd5, 32'd6, 3'd1);
    cycle();
    req0_valid = 1'b0;
    req0_a = 32'h1234_5678;
    req1_valid = 1'b1;
    req1_a = 32'd9;
    cycle();
    check("bp_valid", rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_data", rsp_data, 32'd12);
      check("bp_id", rsp_id, 1'b0);
      check("bp_readies", {req0_ready, req1_ready}, 2'b00);
      cycle();
    end
    rsp_ready = 1'b1;
    cycle();
    check("bp_resume", req1_ready, 1'b1);
    cycle();
    req1_valid = 1'b0;
    cycle();
    cycle();

    // reset while in EXEC
    do_reset();
    drive0(32'd7, 32'd7, 3'd0);
    cycle();
    req0_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rexec_rsp_valid", rsp_valid, 1'b0);
    check("rexec_alu_a", alu_a, 0);
    check("rexec_rsp_data", rsp_data, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      cycle();
      check("rexec_no_rsp", rsp_valid, 1'b0);
    end
    drive0(32'd1, 32'd1, 3'd0);
    drive1(32'd2, 32'd2, 3'd0);
    #1;
    check("rexec_grant0", req0_ready, 1'b1);
    check("rexec_grant1", req1_ready, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
